ifu_prefetch: RTL and testbench

//  Parametrised instruction-fetch unit; successor of the single-word fetch stage.
//  - Owns the fetch PC and issues sequential requests over a valid/ready memory port
//    (no DPI call inside the block).
//  - Buffers returned instructions, tagged with their PC, in a DEPTH-entry prefetch FIFO.
//  - Presents them to decode over a valid/ready handshake; redirect flushes the FIFO.

---
 rtl/ifu_pkg.sv | 20 ++
 rtl/ifu_fifo.sv | 54 +++++
 rtl/ifu_prefetch.sv | 117 +++++++++++
 tb/tb_ifu_prefetch.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// ifu_pkg -- shared defaults and the prefetch entry type for the fetch unit.
// Revision: 1.0
`default_nettype none

package ifu_pkg;

  localparam int unsigned XLEN_DEF         = 32;
  localparam int unsigned ILEN_DEF         = 32;
  localparam int unsigned DEPTH_DEF        = 4;
  localparam int unsigned PC_STEP_DEF      = 4;
  localparam logic [31:0] RESET_VECTOR_DEF = 32'h8000_0000;

  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [ILEN_DEF-1:0] inst;
  } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/ifu_fifo.sv
// ifu_fifo -- DEPTH x WIDTH synchronous FIFO with flush, count, full and empty.
// Revision: 1.0
`default_nettype none

module ifu_fifo #(
  parameter  int unsigned DEPTH = 4,
  parameter  int unsigned WIDTH = 32,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic [CW-1:0]    count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;

  // Storage is not reset: the head is only meaningful while count is non-zero.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i && !rst) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/ifu_prefetch.sv
// ifu_prefetch -- fetch PC, credit-limited sequential requests and a tagged prefetch FIFO.
// Revision: 1.0
`default_nettype none

module ifu_prefetch
  import ifu_pkg::*;
#(
  parameter int unsigned      XLEN         = XLEN_DEF,
  parameter int unsigned      ILEN         = ILEN_DEF,
  parameter int unsigned      DEPTH        = DEPTH_DEF,
  parameter logic [XLEN-1:0]  RESET_VECTOR = XLEN'(RESET_VECTOR_DEF),
  parameter logic [XLEN-1:0]  PC_STEP      = XLEN'(PC_STEP_DEF)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            mem_req_valid_o,
  input  logic            mem_req_ready_i,
  output logic [XLEN-1:0] mem_req_addr_o,
  input  logic            mem_resp_valid_i,
  input  logic [ILEN-1:0] mem_resp_data_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [ILEN-1:0] out_inst_o,
  output logic [XLEN-1:0] out_pc_o
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned EW = XLEN + ILEN;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   discard_q, discard_d;

  logic [CW-1:0]   data_count, tag_count;
  logic            data_full, data_empty, tag_full, tag_empty;
  logic [EW-1:0]   data_head;
  logic [XLEN-1:0] tag_pc;
  logic [CW:0]     credits_used;
  logic            req_fire, push, pop;

  // Every buffered entry and every in-flight request holds one of DEPTH credits.
  assign credits_used    = {1'b0, data_count} + {1'b0, outstanding_q};
  assign mem_req_valid_o = !rst && !redirect_valid_i && (credits_used < (CW+1)'(DEPTH));
  assign mem_req_addr_o  = fetch_pc_q;
  assign req_fire        = mem_req_valid_o && mem_req_ready_i;

  assign push = mem_resp_valid_i && !redirect_valid_i && (discard_q == '0);
  assign pop  = out_valid_o && out_ready_i && !redirect_valid_i;

  assign out_valid_o = !rst && !data_empty;
  assign out_pc_o    = out_valid_o ? data_head[EW-1:ILEN] : '0;
  assign out_inst_o  = out_valid_o ? data_head[ILEN-1:0]  : '0;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    if (redirect_valid_i) begin
      fetch_pc_d    = redirect_pc_i;
      outstanding_d = outstanding_q - CW'(mem_resp_valid_i);
      discard_d     = outstanding_q - CW'(mem_resp_valid_i);
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + PC_STEP;
      outstanding_d = outstanding_q + CW'(req_fire) - CW'(mem_resp_valid_i);
      if (mem_resp_valid_i && (discard_q != '0)) discard_d = discard_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= RESET_VECTOR;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  // Tags are never flushed: dropped responses still retire their tag in order.
  ifu_fifo #(.DEPTH(DEPTH), .WIDTH(XLEN)) u_tag_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (1'b0),
    .push_i  (req_fire),
    .data_i  (fetch_pc_q),
    .pop_i   (mem_resp_valid_i),
    .data_o  (tag_pc),
    .count_o (tag_count),
    .full_o  (tag_full),
    .empty_o (tag_empty)
  );

  ifu_fifo #(.DEPTH(DEPTH), .WIDTH(EW)) u_data_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (redirect_valid_i),
    .push_i  (push),
    .data_i  ({tag_pc, mem_resp_data_i}),
    .pop_i   (pop),
    .data_o  (data_head),
    .count_o (data_count),
    .full_o  (data_full),
    .empty_o (data_empty)
  );

  a_no_push_full:   assert property (@(posedge clk) disable iff (rst) !(push && data_full && !pop));
  a_no_tag_over:    assert property (@(posedge clk) disable iff (rst) !(req_fire && tag_full));
  a_resp_has_tag:   assert property (@(posedge clk) disable iff (rst) !(mem_resp_valid_i && tag_empty));
  a_tags_in_flight: assert property (@(posedge clk) disable iff (rst) tag_count == outstanding_q);

endmodule

`default_nettype wire

// File: tb/tb_ifu_prefetch.sv
// tb_ifu_prefetch -- directed scenarios against a queue-based reference model of the fetch unit.
// Revision: 1.0
`default_nettype none

module tb_ifu_prefetch;
  import ifu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b1;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_resp_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_inst;
  logic [31:0] out_pc;

  ifu_prefetch #(
    .XLEN(32), .ILEN(32), .DEPTH(4), .RESET_VECTOR(32'h8000_0000), .PC_STEP(32'd4)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .redirect_valid_i (redirect_valid),
    .redirect_pc_i    (redirect_pc),
    .mem_req_valid_o  (mem_req_valid),
    .mem_req_ready_i  (mem_req_ready),
    .mem_req_addr_o   (mem_req_addr),
    .mem_resp_valid_i (mem_resp_valid),
    .mem_resp_data_i  (mem_resp_data),
    .out_valid_o      (out_valid),
    .out_ready_i      (out_ready),
    .out_inst_o       (out_inst),
    .out_pc_o         (out_pc)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; bit drop; } flight_t;
  typedef struct { logic [31:0] addr; int due; } mreq_t;

  // Reference model: plain queues for the prefetch buffer and requests in flight.
  fetch_entry_t m_fifo[$];
  flight_t      m_flight[$];
  logic [31:0]  m_pc = 32'h8000_0000;

  mreq_t       mem_q[$];
  int          lat = 1;
  int          cyc = 0;
  logic [31:0] req_log[$];
  logic [31:0] pop_log[$];
  int          checks = 0;
  int          errors = 0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_addr = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  task automatic step();
    bit s_rst, s_redir, s_ready, s_rv, s_oready, e_req, e_out, d_hs;
    logic [31:0] s_rpc, s_rdata, d_addr;
    flight_t fl;
    @(negedge clk);
    s_rst = rst; s_redir = redirect_valid; s_ready = mem_req_ready; s_rv = mem_resp_valid;
    s_oready = out_ready; s_rpc = redirect_pc; s_rdata = mem_resp_data;
    e_req = !s_rst && !s_redir && (m_fifo.size() + m_flight.size() < 4);
    e_out = !s_rst && (m_fifo.size() > 0);
    chk("mem_req_valid", 32'(mem_req_valid), 32'(e_req));
    if (e_req) chk("mem_req_addr", mem_req_addr, m_pc);
    chk("out_valid", 32'(out_valid), 32'(e_out));
    chk("out_pc", out_pc, e_out ? m_fifo[0].pc : 32'h0);
    chk("out_inst", out_inst, e_out ? m_fifo[0].inst : 32'h0);
    if (prev_stall && !s_rst && !s_redir) begin
      chk("req_hold_valid", 32'(mem_req_valid), 32'd1);
      chk("req_hold_addr", mem_req_addr, prev_addr);
    end
    prev_stall = mem_req_valid && !s_ready && !s_redir && !s_rst;
    prev_addr  = mem_req_addr;
    d_hs   = mem_req_valid && s_ready;
    d_addr = mem_req_addr;
    if (d_hs) req_log.push_back(d_addr);
    if (out_valid && s_oready && !s_redir && !s_rst) pop_log.push_back(out_pc);

    @(posedge clk);
    if (s_rst) begin
      m_fifo.delete(); m_flight.delete(); m_pc = 32'h8000_0000;
    end else if (s_redir) begin
      if (s_rv && m_flight.size() > 0) m_flight.delete(0);
      foreach (m_flight[i]) m_flight[i].drop = 1'b1;
      m_fifo.delete();
      m_pc = s_rpc;
    end else begin
      if (e_out && s_oready) m_fifo.delete(0);
      if (s_rv && m_flight.size() > 0) begin
        fl = m_flight[0];
        m_flight.delete(0);
        if (!fl.drop) m_fifo.push_back('{pc: fl.pc, inst: s_rdata});
      end
      if (e_req && s_ready) begin
        m_flight.push_back('{pc: m_pc, drop: 1'b0});
        m_pc = m_pc + 32'd4;
      end
    end
    if (m_fifo.size() > 4) chk("model_fifo_overflow", 32'(m_fifo.size()), 32'd4);

    if (s_rst) mem_q.delete();
    else begin
      if (s_rv && mem_q.size() > 0) mem_q.delete(0);
      if (d_hs) mem_q.push_back('{addr: d_addr, due: cyc + lat});
    end
    cyc++;
    #1;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      mem_resp_valid = 1'b1;
      mem_resp_data  = mem_word(mem_q[0].addr);
    end else begin
      mem_resp_valid = 1'b0;
      mem_resp_data  = '0;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    #1;
    chk("rst_req_valid", 32'(mem_req_valid), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    run(2);
    rst = 1'b0;
    req_log.delete();
    pop_log.delete();
    #1;
    chk("post_rst_out_valid", 32'(out_valid), 32'd0);
    chk("post_rst_addr", mem_req_addr, 32'h8000_0000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    // 1: streaming with a 1-cycle memory
    lat = 1; mem_req_ready = 1'b1; out_ready = 1'b1;
    do_reset();
    run(10);
    chk("t1_req0", req_log[0], 32'h8000_0000);
    chk("t1_req1", req_log[1], 32'h8000_0004);
    chk("t1_req2", req_log[2], 32'h8000_0008);
    chk("t1_pop0", pop_log[0], 32'h8000_0000);
    chk("t1_pop2", pop_log[2], 32'h8000_0008);

    // 2: decode stalled, credits run out after DEPTH requests
    out_ready = 1'b0;
    do_reset();
    run(10);
    #1;
    chk("t2_req_count", 32'(req_log.size()), 32'd4);
    chk("t2_req3", req_log[3], 32'h8000_000C);
    chk("t2_req_stopped", 32'(mem_req_valid), 32'd0);
    out_ready = 1'b1;
    run(3);
    chk("t2_resume", req_log[4], 32'h8000_0010);

    // 3: redirect with three requests in flight
    lat = 4;
    do_reset();
    run(3);
    redirect_valid = 1'b1; redirect_pc = 32'h8000_1000;
    #1;
    chk("t3_no_req_on_redirect", 32'(mem_req_valid), 32'd0);
    step();
    redirect_valid = 1'b0;
    run(12);
    chk("t3_first_pc", pop_log[0], 32'h8000_1000);

    // 4: redirect coinciding with a response and a pop
    lat = 1;
    do_reset();
    run(4);
    redirect_valid = 1'b1; redirect_pc = 32'h8000_2000;
    #1;
    chk("t4_out_valid_before", 32'(out_valid), 32'd1);
    chk("t4_resp_present", 32'(mem_resp_valid), 32'd1);
    chk("t4_no_req", 32'(mem_req_valid), 32'd0);
    step();
    redirect_valid = 1'b0;
    #1;
    chk("t4_fifo_empty", 32'(out_valid), 32'd0);
    chk("t4_new_addr", mem_req_addr, 32'h8000_2000);
    run(6);

    // 5: PC wrap with random request stalls
    do_reset();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    step();
    redirect_valid = 1'b0;
    req_log.delete();
    for (int i = 0; i < 24; i++) begin
      mem_req_ready = (i >= 18) ? 1'b1 : 1'($urandom_range(0, 1));
      step();
    end
    mem_req_ready = 1'b1;
    chk("t5_req0", req_log[0], 32'hFFFF_FFF8);
    chk("t5_req1", req_log[1], 32'hFFFF_FFFC);
    chk("t5_wrap", req_log[2], 32'h0000_0000);

    // 6: reset with buffered entries and requests in flight
    lat = 4; out_ready = 1'b0;
    do_reset();
    run(6);
    #1;
    chk("t6_busy_before_rst", 32'(out_valid), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    req_log.delete();
    #1;
    chk("t6_out_valid", 32'(out_valid), 32'd0);
    chk("t6_out_pc", out_pc, 32'h0);
    chk("t6_req_valid", 32'(mem_req_valid), 32'd1);
    run(2);
    chk("t6_first_req", req_log[0], 32'h8000_0000);
    out_ready = 1'b1;
    run(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
